// File: rtl/ldpc_lift_sel.sv
// ldpc_lift_sel: one-candidate-per-cycle search for the smallest 5G NR lifting size Zc with Kb*Zc >= K'.
// Build option LIFT_SEL_EARLY_EXIT_EN: abandon a lifting set once no later candidate in it can improve.
module ldpc_lift_sel #(
  parameter int ZC_MAX = 384,
  parameter int KP_W   = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [KP_W-1:0] kprime,
  input  logic            bg2_sel,
  output logic [8:0]      zc,
  output logic [2:0]      ils_selected,
  output logic [4:0]      kb,
  output logic            bg1_valid,
  output logic            bg2_valid,
  output logic            lift_err,
  output logic            busy
);
  localparam int PW = (KP_W > 16) ? KP_W : 16;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  state_e          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [KP_W-1:0] kp_q, kp_d;
  logic            bg2_q, bg2_d;
  logic [4:0]      kbl_q, kbl_d;
  logic [8:0]      best_zc_q, best_zc_d;
  logic [2:0]      best_ils_q, best_ils_d;
  logic [8:0]      zc_q, zc_d;
  logic [2:0]      ils_q, ils_d;
  logic [4:0]      kb_q, kb_d;
  logic            bg1_vld_q, bg1_vld_d;
  logic            bg2_vld_q, bg2_vld_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [2:0]      cand_ils, cand_j;
  logic [3:0]      gen;
  logic [10:0]     cand_z;
  logic [PW-1:0]   prod;
  logic            over, fit, last;
  logic [4:0]      kb_req;

  assign cand_ils = idx_q[5:3];
  assign cand_j   = idx_q[2:0];

  always_comb begin
    case (cand_ils)
      3'd0:    gen = 4'd2;
      3'd1:    gen = 4'd3;
      3'd2:    gen = 4'd5;
      3'd3:    gen = 4'd7;
      3'd4:    gen = 4'd9;
      3'd5:    gen = 4'd11;
      3'd6:    gen = 4'd13;
      default: gen = 4'd15;
    endcase
  end

  // Product is kept wider than 14 bits so out-of-range candidates cannot alias into a false fit.
  assign cand_z = {7'd0, gen} << cand_j;
  assign prod   = PW'(kbl_q) * PW'(cand_z);
  assign over   = cand_z > 11'(ZC_MAX);
  assign fit    = !over && (prod >= PW'(kp_q)) && (cand_z < {2'b00, best_zc_q});

`ifdef LIFT_SEL_EARLY_EXIT_EN
  logic [2:0] jmax;
  always_comb begin
    case (cand_ils)
      3'd0, 3'd1:       jmax = 3'd7;
      3'd2:             jmax = 3'd6;
      3'd3, 3'd4, 3'd5: jmax = 3'd5;
      default:          jmax = 3'd4;
    endcase
  end
`endif

  always_comb begin
    if (!bg2_sel)                   kb_req = 5'd22;
    else if (kprime > KP_W'(640))   kb_req = 5'd10;
    else if (kprime > KP_W'(560))   kb_req = 5'd9;
    else if (kprime > KP_W'(192))   kb_req = 5'd8;
    else                            kb_req = 5'd6;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    kp_d       = kp_q;
    bg2_d      = bg2_q;
    kbl_d      = kbl_q;
    best_zc_d  = best_zc_q;
    best_ils_d = best_ils_q;
    zc_d       = zc_q;
    ils_d      = ils_q;
    kb_d       = kb_q;
    bg1_vld_d  = 1'b0;
    bg2_vld_d  = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    last       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          kp_d       = kprime;
          bg2_d      = bg2_sel;
          kbl_d      = kb_req;
          idx_d      = 6'd0;
          best_zc_d  = 9'h1FF;
          best_ils_d = 3'd0;
          busy_d     = 1'b1;
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        if (fit) begin
          best_zc_d  = cand_z[8:0];
          best_ils_d = cand_ils;
        end
`ifdef LIFT_SEL_EARLY_EXIT_EN
        if (fit || over || (cand_j == jmax)) begin
          idx_d = {cand_ils + 3'd1, 3'b000};
          last  = (cand_ils == 3'd7);
        end else begin
          idx_d = idx_q + 6'd1;
        end
`else
        idx_d = idx_q + 6'd1;
        last  = (idx_q == 6'd63);
`endif
        // Result is registered on the edge that evaluates the final candidate.
        if (last) begin
          state_d = DONE;
          if (best_zc_d != 9'h1FF) begin
            zc_d      = best_zc_d;
            ils_d     = best_ils_d;
            kb_d      = kbl_q;
            bg1_vld_d = !bg2_q;
            bg2_vld_d = bg2_q;
          end else begin
            zc_d  = 9'd0;
            ils_d = 3'd0;
            err_d = 1'b1;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 6'd0;
      kp_q       <= '0;
      bg2_q      <= 1'b0;
      kbl_q      <= 5'd0;
      best_zc_q  <= 9'h1FF;
      best_ils_q <= 3'd0;
      zc_q       <= 9'd0;
      ils_q      <= 3'd0;
      kb_q       <= 5'd0;
      bg1_vld_q  <= 1'b0;
      bg2_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      kp_q       <= kp_d;
      bg2_q      <= bg2_d;
      kbl_q      <= kbl_d;
      best_zc_q  <= best_zc_d;
      best_ils_q <= best_ils_d;
      zc_q       <= zc_d;
      ils_q      <= ils_d;
      kb_q       <= kb_d;
      bg1_vld_q  <= bg1_vld_d;
      bg2_vld_q  <= bg2_vld_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready    = !busy_q;
  assign busy         = busy_q;
  assign zc           = zc_q;
  assign ils_selected = ils_q;
  assign kb           = kb_q;
  assign bg1_valid    = bg1_vld_q;
  assign bg2_valid    = bg2_vld_q;
  assign lift_err     = err_q;
endmodule

// File: tb/tb_ldpc_lift_sel.sv
// Bench for ldpc_lift_sel: directed cases plus random K'/BG requests against a set-by-set reference search.
module tb_ldpc_lift_sel;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [13:0] kprime = '0;
  logic        bg2_sel = 1'b0;
  logic [8:0]  zc;
  logic [2:0]  ils_selected;
  logic [4:0]  kb;
  logic        bg1_valid, bg2_valid, lift_err, busy;

  int errors = 0;
  int checks = 0;

`ifdef LIFT_SEL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int A_GEN [8] = '{2, 3, 5, 7, 9, 11, 13, 15};
  localparam int J_MAX [8] = '{7, 7, 6, 5, 5, 5, 4, 4};

  ldpc_lift_sel dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .kprime(kprime), .bg2_sel(bg2_sel), .zc(zc), .ils_selected(ils_selected), .kb(kb),
    .bg1_valid(bg1_valid), .bg2_valid(bg2_valid), .lift_err(lift_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Smallest legal lifting size over all sets, plus the number of candidates the search visits.
  task automatic model(input int kp, input bit bg2, output int ezc, output int eils,
                       output int ekb, output bit eerr, output int elat);
    int best, bi, n, z;
    bit f;
    best = 511; bi = 0; n = 0;
    if (!bg2)          ekb = 22;
    else if (kp > 640) ekb = 10;
    else if (kp > 560) ekb = 9;
    else if (kp > 192) ekb = 8;
    else               ekb = 6;
    for (int s = 0; s < 8; s++) begin
      for (int j = 0; j < 8; j++) begin
        z = A_GEN[s] << j;
        f = (z <= 384) && (ekb * z >= kp) && (z < best);
        if (f) begin best = z; bi = s; end
        n++;
        if (EARLY && (f || z > 384 || j == J_MAX[s])) break;
      end
    end
    eerr = (best == 511);
    ezc  = eerr ? 0 : best;
    eils = eerr ? 0 : bi;
    elat = EARLY ? n : 64;
  endtask

  task automatic run_req(input int kp, input bit bg2, input bit inject);
    int ezc, eils, ekb, elat, lat, zc_hold;
    bit eerr;
    model(kp, bg2, ezc, eils, ekb, eerr, elat);
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    kprime    = kp[13:0];
    bg2_sel   = bg2;
    @(negedge clk);
    req_valid = 1'b0;
    kprime    = 14'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("ready_while_busy", req_ready, 0);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      if (inject && n >= 5 && n < 8) begin
        req_valid = 1'b1;
        kprime    = 14'd100;
        bg2_sel   = ~bg2;
        chk("ready_low_on_inject", req_ready, 0);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (bg1_valid || bg2_valid || lift_err) begin
        lat = n;
        break;
      end
    end
    req_valid = 1'b0;
    chk("latency", lat, elat);
    chk("bg1_valid", bg1_valid, !eerr && !bg2);
    chk("bg2_valid", bg2_valid, !eerr && bg2);
    chk("lift_err", lift_err, eerr);
    chk("zc", zc, ezc);
    chk("ils", ils_selected, eils);
    if (!eerr) chk("kb", kb, ekb);
    chk("busy_in_done", busy, 1);
    zc_hold = zc;
    @(negedge clk);
    chk("strobes_one_cycle", {bg1_valid, bg2_valid, lift_err}, 0);
    chk("busy_fall", busy, 0);
    chk("ready_back", req_ready, 1);
    chk("zc_hold", zc, zc_hold);
  endtask

  initial begin
    int extra;
    repeat (3) @(negedge clk);
    chk("rst_zc", zc, 0);
    chk("rst_ils", ils_selected, 0);
    chk("rst_kb", kb, 0);
    chk("rst_strobes", {bg1_valid, bg2_valid, lift_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    reset_n = 1'b1;

    run_req(8448, 1'b0, 1'b0);
    run_req(100, 1'b1, 1'b0);
    run_req(500, 1'b0, 1'b1);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (bg1_valid || bg2_valid || lift_err || busy) extra++;
    end
    chk("ignored_req_no_activity", extra, 0);
    run_req(3841, 1'b1, 1'b0);

    // Reset in the middle of a search; in-flight result must be discarded.
    run_req(8448, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; kprime = 14'd1000; bg2_sel = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (29) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_zc", zc, 0);
    chk("midrst_ils", ils_selected, 0);
    chk("midrst_kb", kb, 0);
    chk("midrst_strobes", {bg1_valid, bg2_valid, lift_err}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bg1_valid || bg2_valid || lift_err || busy) extra++;
    end
    chk("midrst_no_result", extra, 0);
    run_req(1000, 1'b1, 1'b0);

    run_req(0, 1'b0, 1'b0);
    run_req(0, 1'b1, 1'b0);
    run_req(8449, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int k;
      bit b;
      b = 1'($urandom);
      k = (t % 4 == 3) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, b ? 3840 : 8448));
      run_req(k, b, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
